// File: rtl/hdmi_packet_pkg.sv
// hdmi_packet_pkg: HDMI data-island packet widths, BCH polynomial and serial BCH step.
package hdmi_packet_pkg;
  localparam int PACKET_PIXELS = 32;
  localparam int HEADER_BITS = 24;
  localparam int SUB_BITS = 56;
  localparam logic [7:0] BCH_POLY = 8'h83;
  typedef logic [55:0] packet_sub_t;
  function automatic logic [7:0] bch_next(input logic [7:0] e, input logic b);
    return (e >> 1) ^ ((e[0] ^ b) ? BCH_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/bch_ecc_lane.sv
// bch_ecc_lane: serial BCH parity accumulator taking one or two bits per cycle (bits[0] first).
module bch_ecc_lane import hdmi_packet_pkg::*; #(
  parameter bit DOUBLE = 1'b0
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic       clear,
  input  logic       step,
  input  logic [1:0] bits,
  output logic [7:0] ecc
);
  always_ff @(posedge clk_pixel)
    if (reset || clear) ecc <= '0;
    else if (step) ecc <= DOUBLE ? bch_next(bch_next(ecc, bits[0]), bits[1]) : bch_next(ecc, bits[0]);
endmodule

// File: rtl/data_island_packet_assembler.sv
// data_island_packet_assembler: serialises header + four subpackets with BCH parity over 32 pixels.
// Optional PACKET_INPUT_CAPTURE_EN registers header/sub on the packet_enable edge.
module data_island_packet_assembler import hdmi_packet_pkg::*; (
  input  logic              clk_pixel,
  input  logic              reset,
  input  logic              data_island_period,
  input  logic [23:0]       header,
  input  packet_sub_t [3:0] sub,
  output logic [8:0]        packet_data,
  output logic [4:0]        counter,
  output logic              packet_enable
);
  localparam logic [4:0] LAST = 5'(PACKET_PIXELS - 1);
  localparam logic [4:0] HDR_END = 5'(HEADER_BITS);
  localparam logic [4:0] SUB_END = 5'(SUB_BITS / 2);
  logic              dip_q;
  logic              clear;
  logic              in_hdr;
  logic              in_sub;
  logic [23:0]       hdr;
  packet_sub_t [3:0] sb;
  logic [7:0]        ecc_hdr;
  logic [3:0][7:0]   ecc_sub;
  assign packet_enable = data_island_period && (counter == LAST || !dip_q);
  assign clear = !data_island_period || counter == LAST;
  assign in_hdr = counter < HDR_END;
  assign in_sub = counter < SUB_END;
  always_ff @(posedge clk_pixel)
    if (reset) begin
      counter <= '0;
      dip_q <= 1'b0;
    end else begin
      counter <= data_island_period ? counter + 5'd1 : 5'd0;
      dip_q <= data_island_period;
    end
`ifdef PACKET_INPUT_CAPTURE_EN
  logic [23:0]       cap_hdr;
  packet_sub_t [3:0] cap_sub;
  always_ff @(posedge clk_pixel)
    if (reset) begin
      cap_hdr <= '0;
      cap_sub <= '0;
    end else if (packet_enable) begin
      cap_hdr <= header;
      cap_sub <= sub;
    end
  // During the strobe the live inputs already hold the new packet (needed for c=0 on entry)
  assign hdr = packet_enable ? header : cap_hdr;
  assign sb = packet_enable ? sub : cap_sub;
`else
  assign hdr = header;
  assign sb = sub;
`endif
  bch_ecc_lane #(.DOUBLE(1'b0)) u_hdr (
    .clk_pixel(clk_pixel), .reset(reset), .clear(clear), .step(in_hdr),
    .bits({1'b0, hdr[counter]}), .ecc(ecc_hdr)
  );
  assign packet_data[0] = in_hdr ? hdr[counter] : ecc_hdr[counter[2:0]];
  for (genvar i = 0; i < 4; i++) begin : g_sub
    bch_ecc_lane #(.DOUBLE(1'b1)) u_sub (
      .clk_pixel(clk_pixel), .reset(reset), .clear(clear), .step(in_sub),
      .bits({sb[i][{counter, 1'b1}], sb[i][{counter, 1'b0}]}), .ecc(ecc_sub[i])
    );
    assign packet_data[1+i] = in_sub ? sb[i][{counter, 1'b0}] : ecc_sub[i][{counter[1:0], 1'b0}];
    assign packet_data[5+i] = in_sub ? sb[i][{counter, 1'b1}] : ecc_sub[i][{counter[1:0], 1'b1}];
  end
endmodule

// File: tb/tb_data_island_packet_assembler.sv
// tb_data_island_packet_assembler: randomized self-checking bench against a stream-level packet model.
module tb_data_island_packet_assembler;
  logic             clk_pixel = 1'b0;
  logic             reset = 1'b1;
  logic             data_island_period = 1'b0;
  logic [23:0]      header = '0;
  logic [3:0][55:0] sub = '0;
  logic [8:0]       packet_data;
  logic [4:0]       counter;
  logic             packet_enable;
  int total = 0;
  int bad = 0;
  data_island_packet_assembler dut (
    .clk_pixel(clk_pixel), .reset(reset), .data_island_period(data_island_period),
    .header(header), .sub(sub), .packet_data(packet_data), .counter(counter),
    .packet_enable(packet_enable)
  );
  always #5 clk_pixel = ~clk_pixel;
  logic [4:0]       m_cnt;
  logic             m_prev;
  logic             m_en;
  logic [23:0]      cap_hdr, p_hdr, e_hdr;
  logic [3:0][55:0] cap_sub, p_sub, e_sub;
  logic [8:0]       m_pd;
  logic [14:0]      got, expv;
  function automatic logic [7:0] gold(input logic [7:0] e, input logic b);
    return (e / 8'd2) ^ (((e % 8'd2) != {7'd0, b}) ? 8'd131 : 8'd0);
  endfunction
  function automatic logic [7:0] ecc_of(input logic [55:0] d, input int n);
    logic [7:0] e;
    e = '0;
    for (int k = 0; k < n; k++) e = gold(e, d[k]);
    return e;
  endfunction
  assign m_en = data_island_period && (m_cnt == 5'd31 || !m_prev);
`ifdef PACKET_INPUT_CAPTURE_EN
  assign e_hdr = m_en ? header : cap_hdr;
  assign e_sub = m_en ? sub : cap_sub;
`else
  assign e_hdr = header;
  assign e_sub = sub;
`endif
  // p_* is whatever the current packet started with; parity is always computed from it
  always @(posedge clk_pixel) begin
    if (reset) begin
      m_cnt <= '0; m_prev <= 1'b0;
      cap_hdr <= '0; cap_sub <= '0; p_hdr <= '0; p_sub <= '0;
    end else begin
      m_cnt <= data_island_period ? m_cnt + 5'd1 : 5'd0;
      m_prev <= data_island_period;
      if (m_en) begin cap_hdr <= header; cap_sub <= sub; end
      if (data_island_period && m_cnt == 5'd0) begin p_hdr <= e_hdr; p_sub <= e_sub; end
    end
  end
  always_comb begin
    logic [31:0] hs;
    logic [63:0] ss;
    int c;
    m_pd = '0;
    c = int'(m_cnt);
    hs = {ecc_of({32'd0, p_hdr}, 24), e_hdr};
    m_pd[0] = hs[c];
    for (int i = 0; i < 4; i++) begin
      ss = {ecc_of(p_sub[i], 56), e_sub[i]};
      m_pd[1+i] = ss[2*c];
      m_pd[5+i] = ss[2*c+1];
    end
  end
  assign got = {counter, packet_enable, packet_data};
  assign expv = {m_cnt, m_en, m_pd};
  task automatic tick;
    @(posedge clk_pixel);
    #1;
  endtask
  task automatic rand_inputs;
    header = 24'($urandom);
    for (int i = 0; i < 4; i++) sub[i] = {24'($urandom), $urandom};
  endtask
  task automatic test_reset;
    reset = 1'b1; data_island_period = 1'b0; header = '0; sub = '0;
    tick; tick;
    @(negedge clk_pixel);
    total++; if (counter !== 5'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", counter); end
    total++; if (packet_enable !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", packet_enable); end
    total++; if (packet_data !== 9'h000) begin bad++; $display("FAIL reset_pd got=%h exp=000", packet_data); end
    data_island_period = 1'b1;
    tick;
    @(negedge clk_pixel);
    total++; if (counter !== 5'd0) begin bad++; $display("FAIL reset_wins got=%0d exp=0", counter); end
    reset = 1'b0; data_island_period = 1'b0;
    tick;
  endtask
  task automatic test_null;
    header = '0; sub = '0; data_island_period = 1'b1;
    for (int n = 0; n < 34; n++) begin
      @(negedge clk_pixel);
      total++; if (got !== expv) begin bad++; $display("FAIL null c=%0d got=%h exp=%h", m_cnt, got, expv); end
      total++; if (packet_data !== 9'h000) begin bad++; $display("FAIL null_pd c=%0d got=%h exp=000", m_cnt, packet_data); end
      tick;
    end
  endtask
  task automatic test_header_bit;
    logic [7:0] par;
    par = '0;
    data_island_period = 1'b0; header = 24'h000001; sub = '0;
    tick;
    data_island_period = 1'b1;
    for (int n = 0; n < 32; n++) begin
      @(negedge clk_pixel);
      total++; if (got !== expv) begin bad++; $display("FAIL hdr_model c=%0d got=%h exp=%h", m_cnt, got, expv); end
      if (m_cnt < 5'd24) begin
        total++; if (packet_data[0] !== (m_cnt == 5'd0)) begin bad++; $display("FAIL hdr_bit c=%0d got=%b", m_cnt, packet_data[0]); end
      end else par[m_cnt[2:0]] = packet_data[0];
      tick;
    end
    total++; if (par !== 8'h4A) begin bad++; $display("FAIL hdr_ecc got=%h exp=4a", par); end
    total++; if (par !== ecc_of(56'h1, 24)) begin bad++; $display("FAIL hdr_ecc_gold got=%h exp=%h", par, ecc_of(56'h1, 24)); end
  endtask
  task automatic test_sub_order;
    data_island_period = 1'b0; header = '0; sub = '0; sub[2] = 56'h1;
    tick;
    data_island_period = 1'b1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk_pixel);
      total++; if (got !== expv) begin bad++; $display("FAIL sub_model c=%0d got=%h exp=%h", m_cnt, got, expv); end
      if (n == 0) begin
        total++; if (packet_data[3] !== 1'b1) begin bad++; $display("FAIL sub_even got=%b exp=1", packet_data[3]); end
        total++; if (packet_data[7] !== 1'b0) begin bad++; $display("FAIL sub_odd_lo got=%b exp=0", packet_data[7]); end
      end
      if (n == 32) begin
        total++; if (packet_data[7:3] !== 5'b10000) begin bad++; $display("FAIL sub_odd got=%b exp=10000", packet_data[7:3]); end
      end
      tick;
      if (m_cnt == 5'd31) sub[2] = 56'h2;
    end
  endtask
  task automatic test_abort;
    data_island_period = 1'b0; rand_inputs;
    tick;
    data_island_period = 1'b1;
    while (m_cnt != 5'd10) begin
      @(negedge clk_pixel);
      total++; if (got !== expv) begin bad++; $display("FAIL abort_pre c=%0d got=%h exp=%h", m_cnt, got, expv); end
      tick;
    end
    data_island_period = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk_pixel);
      total++; if (got !== expv) begin bad++; $display("FAIL abort_idle c=%0d got=%h exp=%h", m_cnt, got, expv); end
      tick;
    end
    data_island_period = 1'b1; rand_inputs;
    @(negedge clk_pixel);
    total++; if ({counter, packet_enable} !== 6'b000001) begin bad++; $display("FAIL abort_reentry got=%0d/%b exp=0/1", counter, packet_enable); end
    for (int n = 0; n < 32; n++) begin
      if (n > 0) @(negedge clk_pixel);
      total++; if (got !== expv) begin bad++; $display("FAIL abort_post c=%0d got=%h exp=%h", m_cnt, got, expv); end
      tick;
    end
  endtask
  task automatic test_reset_mid;
    data_island_period = 1'b0; rand_inputs;
    tick;
    data_island_period = 1'b1;
    while (m_cnt != 5'd20) begin
      @(negedge clk_pixel);
      total++; if (got !== expv) begin bad++; $display("FAIL rst_pre c=%0d got=%h exp=%h", m_cnt, got, expv); end
      tick;
    end
    reset = 1'b1; header = '0; sub = '0;
    tick;
    reset = 1'b0;
    @(negedge clk_pixel);
    total++; if (counter !== 5'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", counter); end
    total++; if (packet_data !== 9'h000) begin bad++; $display("FAIL rst_pd got=%h exp=000", packet_data); end
    for (int n = 0; n < 32; n++) begin
      if (n > 0) @(negedge clk_pixel);
      total++; if (got !== expv) begin bad++; $display("FAIL rst_post c=%0d got=%h exp=%h", m_cnt, got, expv); end
      total++; if (packet_data !== 9'h000) begin bad++; $display("FAIL rst_ecc c=%0d got=%h exp=000", m_cnt, packet_data); end
      tick;
    end
  endtask
  task automatic test_back_to_back;
    data_island_period = 1'b0; rand_inputs;
    tick;
    data_island_period = 1'b1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk_pixel);
      total++; if (got !== expv) begin bad++; $display("FAIL b2b c=%0d got=%h exp=%h", m_cnt, got, expv); end
      tick;
      if (m_cnt == 5'd31) rand_inputs;
`ifdef PACKET_INPUT_CAPTURE_EN
      if (m_cnt == 5'd5) rand_inputs;
`endif
    end
  endtask
  task automatic test_random;
    data_island_period = 1'b0; rand_inputs;
    tick;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk_pixel);
      total++; if (got !== expv) begin bad++; $display("FAIL rand c=%0d got=%h exp=%h", m_cnt, got, expv); end
      tick;
      if ($urandom_range(23) == 0) data_island_period = ~data_island_period;
      if (!data_island_period || m_cnt == 5'd31 || !m_prev) rand_inputs;
    end
  endtask
  initial begin
    test_reset;
    test_null;
    test_header_bit;
    test_sub_order;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
